// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared UART link definitions (FSM states, oversampling constants)
// Used by uart_rx; the state encoding matches the partner transmitter.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_t;

  localparam int OVERSAMPLE = 16;  // baud ticks per bit
  localparam int MID_TICK   = 7;   // tick index at the middle of the start bit

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// rtl/uart_rx_sync_2ff.sv - two-flop synchroniser for an asynchronous single-bit input
// Ports:
//   clk   in  system clock
//   reset in  asynchronous active-low reset; both flops reset to 1 (idle-high line)
//   d     in  asynchronous input
//   q     out synchronised output
module uart_rx_sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x-oversampling UART receiver
// Ports:
//   clk            in  system clock, rising edge
//   reset          in  asynchronous active-low reset
//   rx             in  serial line, asynchronous, idles high
//   s_tick         in  1-clk baud x16 enable
//   dout           out received byte, right-aligned, upper unused bits 0
//   rx_done_tick   out 1-clk pulse, good frame, dout updated
//   frame_err_tick out 1-clk pulse, stop bit sampled low
//   rx_busy        out high while the FSM is not idle
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       s_tick,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       frame_err_tick,
  output logic       rx_busy
);

  state_t     state_reg, state_next;
  logic [4:0] s_reg, s_next;
  logic [2:0] n_reg, n_next;
  logic [7:0] b_reg, b_next;
  logic [7:0] dout_reg, dout_next;
  logic       done_reg, done_next;
  logic       ferr_reg, ferr_next;
  logic       rx_s;
  logic       rx_prev;
  logic       rx_fall;

  uart_rx_sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // Edge detect: only a falling edge starts a frame, so a line stuck low
  // (break or a frame error tail) cannot retrigger the receiver.
  assign rx_fall = rx_prev & ~rx_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      dout_reg  <= '0;
      done_reg  <= 1'b0;
      ferr_reg  <= 1'b0;
      rx_prev   <= 1'b1;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      dout_reg  <= dout_next;
      done_reg  <= done_next;
      ferr_reg  <= ferr_next;
      rx_prev   <= rx_s;
    end
  end

  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    dout_next  = dout_reg;
    done_next  = 1'b0;
    ferr_next  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (rx_fall) begin
          state_next = START;
          s_next     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_reg == 5'(MID_TICK)) begin
            s_next = '0;
            if (!rx_s) begin
              state_next = DATA;
              n_next     = '0;
            end else begin
              // line went back high before mid-bit: treat as a glitch
              state_next = IDLE;
            end
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_reg == 5'(OVERSAMPLE - 1)) begin
            s_next = '0;
            b_next = {rx_s, b_reg[7:1]};
            if (n_reg == 3'(DBIT - 1)) begin
              state_next = STOP;
            end else begin
              n_next = n_reg + 3'd1;
            end
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_reg == 5'(SB_TICK - 1)) begin
            // Sampling lands mid stop bit, so IDLE is reached before the
            // line can carry the next start edge.
            state_next = IDLE;
            s_next     = '0;
            if (rx_s) begin
              // LSB-first shifting leaves the frame in the top DBIT bits
              dout_next = b_reg >> (8 - DBIT);
              done_next = 1'b1;
            end else begin
              ferr_next = 1'b1;
            end
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign dout           = dout_reg;
  assign rx_done_tick   = done_reg;
  assign frame_err_tick = ferr_reg;
  assign rx_busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed, table-driven bench for uart_rx
module tb_uart_rx;

  localparam int BIT_CLK = 64;  // 16 ticks x 4 clk per tick

  logic       clk;
  logic       reset;
  logic       rx;
  logic       rx2;
  logic       s_tick;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err_tick;
  logic       rx_busy;
  logic [7:0] dout2;
  logic       done2;
  logic       ferr2;
  logic       busy2;
  logic [1:0] tick_div;

  uart_rx u_dut (
    .clk            (clk),
    .reset          (reset),
    .rx             (rx),
    .s_tick         (s_tick),
    .dout           (dout),
    .rx_done_tick   (rx_done_tick),
    .frame_err_tick (frame_err_tick),
    .rx_busy        (rx_busy)
  );

  uart_rx #(.DBIT(7), .SB_TICK(32)) u_dut7 (
    .clk            (clk),
    .reset          (reset),
    .rx             (rx2),
    .s_tick         (s_tick),
    .dout           (dout2),
    .rx_done_tick   (done2),
    .frame_err_tick (ferr2),
    .rx_busy        (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    tick_div <= tick_div + 2'd1;
  end
  assign s_tick = (tick_div == 2'd3);

  int         done_cnt = 0;
  int         ferr_cnt = 0;
  int         both_cnt = 0;
  int         done2_cnt = 0;
  int         ferr2_cnt = 0;
  int         hidx = 0;
  logic [7:0] hist [0:15];

  always @(negedge clk) begin
    if (rx_done_tick) begin
      done_cnt   <= done_cnt + 1;
      hist[hidx[3:0]] <= dout;
      hidx       <= hidx + 1;
    end
    if (frame_err_tick) ferr_cnt <= ferr_cnt + 1;
    if (rx_done_tick && frame_err_tick) both_cnt <= both_cnt + 1;
    if (done2) done2_cnt <= done2_cnt + 1;
    if (ferr2) ferr2_cnt <= ferr2_cnt + 1;
  end

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_line(input int which, input logic v);
    if (which == 0) rx = v;
    else rx2 = v;
  endtask

  task automatic hold(input int which, input logic v, input int nclk);
    set_line(which, v);
    repeat (nclk) @(negedge clk);
  endtask

  task automatic send_frame(input int which, input logic [7:0] data, input int nbits,
                            input logic stopv, input int stop_clk);
    logic [7:0] d;
    d = data;
    hold(which, 1'b0, BIT_CLK);
    for (int i = 0; i < nbits; i++) hold(which, d[i], BIT_CLK);
    hold(which, stopv, stop_clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stopv;
    int         post_low;
    logic [7:0] exp_dout;
    int         exp_done;
    int         exp_ferr;
  } vec_t;

  vec_t vecs [0:2];
  int d0, f0;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 0,    8'hA5, 1, 0};
    vecs[1] = '{8'h3C, 1'b0, 1920, 8'hA5, 0, 1};
    vecs[2] = '{8'h81, 1'b1, 0,    8'h81, 1, 0};

    tick_div = 2'd0;
    rx       = 1'b1;
    rx2      = 1'b1;
    reset    = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_dout", dout, 8'h00);
    check("reset_done", rx_done_tick, 0);
    check("reset_ferr", frame_err_tick, 0);
    check("reset_busy", rx_busy, 0);
    reset = 1'b1;
    repeat (20) @(negedge clk);

    // Single frames: good byte, framing error with stuck-low tail, recovery
    for (int v = 0; v < 3; v++) begin
      d0 = done_cnt;
      f0 = ferr_cnt;
      send_frame(0, vecs[v].data, 8, vecs[v].stopv, BIT_CLK);
      if (vecs[v].post_low > 0) begin
        hold(0, 1'b0, vecs[v].post_low);
        check($sformatf("v%0d_idle_while_low", v), rx_busy, 0);
      end
      hold(0, 1'b1, 2 * BIT_CLK);
      check($sformatf("v%0d_done_cnt", v), done_cnt - d0, vecs[v].exp_done);
      check($sformatf("v%0d_ferr_cnt", v), ferr_cnt - f0, vecs[v].exp_ferr);
      check($sformatf("v%0d_dout", v), dout, vecs[v].exp_dout);
      check($sformatf("v%0d_busy", v), rx_busy, 0);
    end

    // Start-bit glitch: 4 ticks low, rejected at mid-bit
    d0 = done_cnt;
    f0 = ferr_cnt;
    hold(0, 1'b0, 16);
    check("glitch_busy_seen", rx_busy, 1);
    hold(0, 1'b1, 40);
    check("glitch_busy_clear", rx_busy, 0);
    hold(0, 1'b1, 4 * BIT_CLK);
    check("glitch_no_done", done_cnt - d0, 0);
    check("glitch_no_ferr", ferr_cnt - f0, 0);
    check("glitch_dout", dout, 8'h81);

    // Back-to-back frames, no idle between stop and next start
    d0 = done_cnt;
    send_frame(0, 8'h00, 8, 1'b1, BIT_CLK);
    send_frame(0, 8'hFF, 8, 1'b1, BIT_CLK);
    send_frame(0, 8'h55, 8, 1'b1, BIT_CLK);
    hold(0, 1'b1, 2 * BIT_CLK);
    check("b2b_done_cnt", done_cnt - d0, 3);
    check("b2b_first", hist[4'(d0)], 8'h00);
    check("b2b_second", hist[4'(d0 + 1)], 8'hFF);
    check("b2b_third", hist[4'(d0 + 2)], 8'h55);
    check("never_both", both_cnt, 0);

    // Reset during data bit 3 of 0xC3
    d0 = done_cnt;
    f0 = ferr_cnt;
    hold(0, 1'b0, BIT_CLK);
    hold(0, 1'b1, BIT_CLK);
    hold(0, 1'b1, BIT_CLK);
    hold(0, 1'b0, BIT_CLK);
    hold(0, 1'b0, BIT_CLK / 2);
    reset = 1'b0;
    rx    = 1'b1;
    #1;
    check("rst_mid_dout", dout, 8'h00);
    check("rst_mid_busy", rx_busy, 0);
    check("rst_mid_done", rx_done_tick, 0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    hold(0, 1'b1, 12 * BIT_CLK);
    check("rst_mid_no_done", done_cnt - d0, 0);
    check("rst_mid_no_ferr", ferr_cnt - f0, 0);
    send_frame(0, 8'h5A, 8, 1'b1, BIT_CLK);
    hold(0, 1'b1, 2 * BIT_CLK);
    check("after_rst_done", done_cnt - d0, 1);
    check("after_rst_dout", dout, 8'h5A);

    // DBIT=7, two stop bits
    send_frame(1, 8'h55, 7, 1'b1, 2 * BIT_CLK);
    hold(1, 1'b1, 2 * BIT_CLK);
    check("d7_done_cnt", done2_cnt, 1);
    check("d7_ferr_cnt", ferr2_cnt, 0);
    check("d7_dout", dout2, 8'h55);
    check("d7_busy", busy2, 0);
    send_frame(1, 8'h2A, 7, 1'b1, 2 * BIT_CLK);
    hold(1, 1'b1, 2 * BIT_CLK);
    check("d7_dout_2a", dout2, 8'h2A);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
